// File: rtl/riscv_run_monitor.sv
// Run-control / debug monitor for the riscv core.
// Watches the fetch PC for halt addresses and runs a cycle watchdog.
// It also counts IO-page loads and stores. After a halt it freezes the
// core and streams a data-memory window out as byte-swapped words.
module riscv_run_monitor #(
    parameter int                NBP        = 2,
    parameter logic [NBP*32-1:0] BP_ADDRS   = {32'hFFFFFFFC, 32'h00000064},
    parameter logic [31:0]       TIMEOUT    = 32'd400000000,
    parameter int                AW         = 13,
    parameter int                DUMP_BASE  = 0,
    parameter int                DUMP_WORDS = 1024,
    parameter logic [11:0]       IO_PAGE    = 12'h001
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic [31:0]   PC_IF,
    input  logic          PC_VALID,
    input  logic          DMWE,
    input  logic          DMRE,
    input  logic [29:0]   MADDR,
    output logic          DM_RE,
    output logic [AW-1:0] DM_RADDR,
    input  logic [31:0]   DM_RDATA,
    output logic          HALT,
    output logic          DUMP_VALID,
    input  logic          DUMP_READY,
    output logic [31:0]   DUMP_ADDR,
    output logic [31:0]   DUMP_DATA,
    output logic          DONE,
    output logic          TIMED_OUT,
    output logic [3:0]    HIT_IDX,
    output logic [31:0]   CYCLES,
    output logic [15:0]   IO_ST_CNT,
    output logic [15:0]   IO_LD_CNT
);

    typedef enum logic [1:0] {RUN, RD, OUT, DONE_S} state_t;

    // The index arithmetic wraps modulo the dmem size, so the last index is
    // simply the truncated end of the window.
    localparam logic [AW-1:0] BASE_IDX = AW'(DUMP_BASE);
    localparam logic [AW-1:0] LAST_IDX = AW'(DUMP_BASE + DUMP_WORDS - 1);

    function automatic logic [31:0] byte_swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          first_q, first_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   cycles_q, cycles_d;
    logic [15:0]   io_st_q, io_st_d;
    logic [15:0]   io_ld_q, io_ld_d;
    logic          timed_q, timed_d;
    logic [3:0]    hit_idx_q, hit_idx_d;

    logic [NBP-1:0] bp_match;
    logic [3:0]     hit_idx_c;
    logic           hit;
    logic           io_page;
    logic [31:0]    dump_data_c;
    logic           unused_maddr_lo;

    // Only the page bits of the address matter for IO classification.
    assign unused_maddr_lo = ^MADDR[17:0];
    assign io_page         = (MADDR[29:18] == IO_PAGE);

    genvar gi;
    generate
        for (gi = 0; gi < NBP; gi++) begin : g_bp
            assign bp_match[gi] = PC_VALID && (PC_IF == BP_ADDRS[32*gi +: 32]);
        end
    endgenerate

    // Priority encode the matching channels, lowest index wins.
    always_comb begin
        hit_idx_c = 4'd0;
        for (int k = NBP - 1; k >= 0; k--) begin
            if (bp_match[k]) begin
                hit_idx_c = 4'(k);
            end
        end
    end

    assign hit = |bp_match;

    // Next-state logic for run control, counters and the dump sequencer.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        first_d   = 1'b0;
        data_d    = data_q;
        cycles_d  = cycles_q;
        io_st_d   = io_st_q;
        io_ld_d   = io_ld_q;
        timed_d   = timed_q;
        hit_idx_d = hit_idx_q;
        // The read word arrives on the first OUT cycle; pass it straight
        // through then, and present the captured copy while stalled.
        dump_data_c = first_q ? byte_swap(DM_RDATA) : data_q;
        case (state_q)
            RUN: begin
                if (cycles_q != 32'hFFFF_FFFF) begin
                    cycles_d = cycles_q + 32'd1;
                end
                if (DMWE && io_page && (io_st_q != 16'hFFFF)) begin
                    io_st_d = io_st_q + 16'd1;
                end
                if (DMRE && io_page && (io_ld_q != 16'hFFFF)) begin
                    io_ld_d = io_ld_q + 16'd1;
                end
                if (hit) begin
                    hit_idx_d = hit_idx_c;
                    state_d   = RD;
                end else if ((TIMEOUT != 32'd0) && (cycles_q == TIMEOUT - 32'd1)) begin
                    timed_d = 1'b1;
                    state_d = RD;
                end
            end
            RD: begin
                first_d = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                data_d = dump_data_c;
                if (DUMP_READY) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE_S;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = RD;
                    end
                end
            end
            DONE_S: begin
                state_d = DONE_S;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State register; reset aborts any dump in progress.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= RUN;
            idx_q     <= BASE_IDX;
            first_q   <= 1'b0;
            data_q    <= 32'd0;
            cycles_q  <= 32'd0;
            io_st_q   <= 16'd0;
            io_ld_q   <= 16'd0;
            timed_q   <= 1'b0;
            hit_idx_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            first_q   <= first_d;
            data_q    <= data_d;
            cycles_q  <= cycles_d;
            io_st_q   <= io_st_d;
            io_ld_q   <= io_ld_d;
            timed_q   <= timed_d;
            hit_idx_q <= hit_idx_d;
        end
    end

    assign DM_RE      = (state_q == RD);
    assign DM_RADDR   = idx_q;
    assign HALT       = (state_q != RUN);
    assign DUMP_VALID = (state_q == OUT);
    assign DUMP_ADDR  = DUMP_VALID ? (32'(idx_q) << 2) : 32'd0;
    assign DUMP_DATA  = dump_data_c;
    assign DONE       = (state_q == DONE_S);
    assign TIMED_OUT  = timed_q;
    assign HIT_IDX    = hit_idx_q;
    assign CYCLES     = cycles_q;
    assign IO_ST_CNT  = io_st_q;
    assign IO_LD_CNT  = io_ld_q;

endmodule

// File: tb/tb_riscv_run_monitor.sv
// Scoreboard bench for riscv_run_monitor: a small window that wraps the
// memory, two halt channels and a short watchdog.
module tb_riscv_run_monitor;

    localparam int          NBP   = 2;
    localparam int          AW    = 4;
    localparam int          BASE  = 14;
    localparam int          WORDS = 4;
    localparam int          TMO   = 100;
    localparam int          MSIZE = 16;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic [31:0] PC_IF = '0;
    logic        PC_VALID = 1'b0;
    logic        DMWE = 1'b0;
    logic        DMRE = 1'b0;
    logic [29:0] MADDR = '0;
    logic        DM_RE;
    logic [AW-1:0] DM_RADDR;
    logic [31:0] DM_RDATA = '0;
    logic        HALT;
    logic        DUMP_VALID;
    logic        DUMP_READY = 1'b0;
    logic [31:0] DUMP_ADDR;
    logic [31:0] DUMP_DATA;
    logic        DONE;
    logic        TIMED_OUT;
    logic [3:0]  HIT_IDX;
    logic [31:0] CYCLES;
    logic [15:0] IO_ST_CNT;
    logic [15:0] IO_LD_CNT;

    always #5 CLK = ~CLK;

    riscv_run_monitor #(
        .NBP(NBP), .BP_ADDRS({32'h00000080, 32'h00000064}), .TIMEOUT(32'd100),
        .AW(AW), .DUMP_BASE(BASE), .DUMP_WORDS(WORDS), .IO_PAGE(12'h001)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .PC_IF(PC_IF), .PC_VALID(PC_VALID),
        .DMWE(DMWE), .DMRE(DMRE), .MADDR(MADDR), .DM_RE(DM_RE),
        .DM_RADDR(DM_RADDR), .DM_RDATA(DM_RDATA), .HALT(HALT),
        .DUMP_VALID(DUMP_VALID), .DUMP_READY(DUMP_READY), .DUMP_ADDR(DUMP_ADDR),
        .DUMP_DATA(DUMP_DATA), .DONE(DONE), .TIMED_OUT(TIMED_OUT),
        .HIT_IDX(HIT_IDX), .CYCLES(CYCLES), .IO_ST_CNT(IO_ST_CNT),
        .IO_LD_CNT(IO_LD_CNT)
    );

    // Behavioural dmem port B: one-cycle registered read.
    logic [31:0] mem [MSIZE];
    always @(posedge CLK) if (DM_RE) DM_RDATA <= mem[DM_RADDR];

    logic [31:0] bp [NBP] = '{32'h00000064, 32'h00000080};

    typedef struct { logic [31:0] addr; logic [31:0] data; } word_t;
    word_t exp_q[$];
    int vectors = 0;
    int errors  = 0;
    int dmre_cnt = 0;

    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: compare every presented dump word with the scoreboard head.
    always @(negedge CLK) begin
        if (RSTN) begin
            if (DM_RE) begin
                dmre_cnt++;
                check("dm_re_only_when_halted", {31'd0, HALT}, 32'd1);
            end
            if (DUMP_VALID) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL spurious_word: got addr %h data %h, required no word", DUMP_ADDR, DUMP_DATA);
                end else begin
                    check("dump_addr", DUMP_ADDR, exp_q[0].addr);
                    check("dump_data", DUMP_DATA, exp_q[0].data);
                    if (DUMP_READY) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_halt",    {31'd0, HALT}, 32'd0);
        check("rst_valid",   {31'd0, DUMP_VALID}, 32'd0);
        check("rst_done",    {31'd0, DONE}, 32'd0);
        check("rst_dm_re",   {31'd0, DM_RE}, 32'd0);
        check("rst_timeout", {31'd0, TIMED_OUT}, 32'd0);
        check("rst_hit_idx", {28'd0, HIT_IDX}, 32'd0);
        check("rst_cycles",  CYCLES, 32'd0);
        check("rst_io_st",   {16'd0, IO_ST_CNT}, 32'd0);
        check("rst_io_ld",   {16'd0, IO_LD_CNT}, 32'd0);
        check("rst_addr",    DUMP_ADDR, 32'd0);
        check("rst_data",    DUMP_DATA, 32'd0);
        check("rst_raddr",   {28'd0, DM_RADDR}, BASE);
    endtask

    // One run/halt/dump episode.
    // hit_n: >0 force a hit at RUN cycle hit_n on channel hit_ch, 0 never hit,
    // -1 fully random PC stream. io_dir: directed IO traffic and READY=1.
    task automatic episode(input int hit_n, input int hit_ch, input bit io_dir,
                           input bit stall, input bit abort);
        int n, cyc, st, ld, idx, stall_cnt;
        bit halted, timed;
        RSTN = 1'b0;
        PC_VALID = 1'b0; DMWE = 1'b0; DMRE = 1'b0; MADDR = '0; PC_IF = '0;
        DUMP_READY = 1'b0;
        exp_q.delete();
        for (int i = 0; i < MSIZE; i++) mem[i] = $urandom;
        if (io_dir) mem[BASE] = 32'h11223344;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs();
        dmre_cnt = 0;
        RSTN = 1'b1;
        n = 0; st = 0; ld = 0; idx = 0; halted = 0; timed = 0;
        // Run phase: n counts RUN cycles, the model stops on hit or watchdog.
        while (!halted) begin
            n++;
            if (io_dir) begin
                DMWE  = (n <= 3) || (n == 6);
                DMRE  = (n == 4) || (n == 5);
                MADDR = (n <= 3) ? 30'h0004_0000 : (n <= 5) ? 30'h0004_0001 : 30'h0;
            end else begin
                DMWE  = 1'($urandom);
                DMRE  = 1'($urandom);
                MADDR = {(($urandom % 3) == 0) ? 12'h001 : 12'($urandom), 18'($urandom)};
            end
            if (hit_n >= 0) begin
                if (n == hit_n) begin
                    PC_VALID = 1'b1;
                    PC_IF    = bp[hit_ch];
                end else begin
                    PC_VALID = 1'($urandom);
                    PC_IF    = PC_VALID ? ($urandom | 32'd1) : bp[$urandom % NBP];
                end
            end else begin
                PC_VALID = 1'($urandom);
                PC_IF    = (($urandom % 25) == 0) ? bp[$urandom % NBP] : $urandom;
            end
            if (DMWE && MADDR[29:18] == 12'h001) st++;
            if (DMRE && MADDR[29:18] == 12'h001) ld++;
            for (int k = NBP - 1; k >= 0; k--) begin
                if (PC_VALID && PC_IF == bp[k]) begin
                    halted = 1;
                    idx = k;
                end
            end
            if (!halted && n == TMO) begin
                halted = 1;
                timed = 1;
            end
            @(posedge CLK);
            #1;
            check("halt_flag", {31'd0, HALT}, {31'd0, halted});
        end
        check("cycles_at_halt", CYCLES, n);
        check("timed_out", {31'd0, TIMED_OUT}, {31'd0, timed});
        check("hit_idx", {28'd0, HIT_IDX}, idx);
        check("io_st_cnt", {16'd0, IO_ST_CNT}, st);
        check("io_ld_cnt", {16'd0, IO_LD_CNT}, ld);
        $display("episode halt: cycle %0d hit_idx %0d timed_out %0d io_st %0d io_ld %0d",
                 n, idx, timed, st, ld);
        for (int w = 0; w < WORDS; w++) begin
            int i;
            word_t e;
            i = (BASE + w) % MSIZE;
            e.addr = i * 4;
            e.data = bswap(mem[i]);
            exp_q.push_back(e);
        end
        // Dump phase: core activity must no longer affect the counters.
        DMWE = 1'b1; DMRE = 1'b1; MADDR = 30'h0004_0000;
        PC_VALID = 1'b1; PC_IF = bp[0];
        cyc = 0; stall_cnt = 0;
        while (!DONE && cyc < 200) begin
            if (abort && DUMP_VALID && (WORDS - exp_q.size()) == 2) begin
                RSTN = 1'b0;
                #1;
                check("abort_valid", {31'd0, DUMP_VALID}, 32'd0);
                check("abort_halt",  {31'd0, HALT}, 32'd0);
                check("abort_dm_re", {31'd0, DM_RE}, 32'd0);
                check("abort_cycles", CYCLES, 32'd0);
                check("abort_raddr", {28'd0, DM_RADDR}, BASE);
                $display("episode aborted by reset during word 2");
                exp_q.delete();
                return;
            end
            if (stall && DUMP_VALID && (WORDS - exp_q.size()) == 1 && stall_cnt < 5) begin
                DUMP_READY = 1'b0;
                stall_cnt++;
            end else begin
                DUMP_READY = (io_dir || stall) ? 1'b1 : 1'($urandom);
            end
            @(posedge CLK);
            #1;
            cyc++;
        end
        check("done", {31'd0, DONE}, 32'd1);
        check("done_valid", {31'd0, DUMP_VALID}, 32'd0);
        check("done_halt", {31'd0, HALT}, 32'd1);
        check("words_left", exp_q.size(), 32'd0);
        check("dm_re_count", dmre_cnt, WORDS);
        check("cycles_frozen", CYCLES, n);
        check("io_st_frozen", {16'd0, IO_ST_CNT}, st);
        if (io_dir) check("dump_throughput", cyc, 2 * WORDS);
        if (stall) check("stall_len", stall_cnt, 32'd5);
        repeat (3) @(posedge CLK);
        #1;
        check("done_sticky", {31'd0, DONE}, 32'd1);
        check("dm_re_after_done", dmre_cnt, WORDS);
        $display("episode dump: %0d words in %0d cycles", WORDS, cyc);
    endtask

    initial begin
        episode(50, 0, 1, 0, 0);    // directed hit at 0x64, IO counts, full-rate dump
        episode(37, 1, 0, 1, 0);    // channel 1 hit, 5-cycle stall on word 1
        episode(0, 0, 0, 0, 0);     // watchdog only
        episode(100, 1, 0, 0, 0);   // hit on the watchdog cycle wins
        episode(60, 0, 0, 0, 1);    // reset during the dump
        episode(20, 0, 0, 0, 0);    // dump restarts at the base after abort
        for (int r = 0; r < 6; r++) episode(-1, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
